uart_tx_sb_ctrl: RTL and testbench
==================================

Name: uart_tx_sb_ctrl

Overview:
System-bus slave peripheral that serialises bytes onto the UART tx line. It sits directly downstream of the LSU/address decoder in the RISC-V unit and is selected by a one-hot req_i from the top-level decode. It takes 32-bit word accesses with a 24-bit local offset, buffers bytes in a small FIFO and emits 8-bit frames with optional even parity and 1 or 2 stop bits.

Parameters:
CLK_FREQ, 10_000_000, sysclk frequency in Hz
DEFAULT_BAUD, 115200, baud rate loaded at reset
FIFO_DEPTH, 4, tx byte FIFO entries (power of 2, >=2)

Ports:
clk_i  in  1  system clock (sysclk)
resetn_i  in  1  asynchronous active-low reset
req_i  in  1  bus request, already qualified by address decode
write_enable_i  in  1  1 = write, 0 = read
addr_i  in  32  local byte offset (bits 31:24 are zero)
write_data_i  in  32  write data
read_data_o  out  32  read data, registered
tx_o  out  1  UART transmit line, idle high

Behaviour:
- Reset (resetn_i low, async): tx_o=1, read_data_o=0, FIFO empty, FSM IDLE, divisor=CLK_FREQ/DEFAULT_BAUD (elaboration-time constant, truncated), parity_en=0, stopbit=0, overflow=0.
- Register map (word offsets; other offsets: write ignored, read returns 0):
  0x00 DATA  W: push write_data_i[7:0]; R: 0
  0x04 STATUS  R: {29'b0, overflow, fifo_full, busy}; W ignored; a read clears overflow on the same cycle read_data_o is loaded
  0x08 DIVISOR  RW: [15:0] clocks per bit; writing 0 or 1 stores 2
  0x0C PARITY_EN  RW: [0]
  0x10 STOPBIT  RW: [0], 0 = 1 stop bit, 1 = 2 stop bits
  0x24 RESET  W: writing 1 in bit 0 performs a soft reset equal to hardware reset; R: 0
- Read latency: read_data_o is loaded on the clock edge where req_i=1 and write_enable_i=0, and holds until the next read. No wait states.
- busy = (FSM != IDLE) || FIFO not empty.
- Config writes (0x08/0x0C/0x10) are accepted only when busy=0. Otherwise they are silently dropped.
- DATA write with FIFO full: the byte is dropped and overflow is set. A push while the FSM pops the same cycle and the FIFO is full is also dropped; pop is not considered.
- FSM: IDLE -> START when FIFO not empty. Pop the byte into a shift register and drive tx_o=0. START -> DATA after divisor cycles. DATA shifts 8 bits LSB first, divisor cycles each. Then PARITY if parity_en, else STOP. PARITY drives XOR of the 8 data bits (even parity). STOP drives 1 for divisor cycles, or 2*divisor if stopbit=1. STOP -> START directly if the FIFO is not empty (back-to-back frames, no idle gap), else IDLE.
- Baud counter counts divisor-1 down to 0. The bit boundary is at 0. The counter reloads at every bit boundary. Config is sampled only in IDLE, so a frame's format is fixed at START.
- tx_o is driven from a flop, so there are no combinational glitches.
- Soft reset or hardware reset mid-frame aborts immediately, and tx_o returns to 1 on the next edge (or asynchronously for resetn_i).

Decomposition:
- Shared package uart_pkg:
  - register offset localparams (DATA/STATUS/DIVISOR/PARITY_EN/STOPBIT/RESET)
  - FSM state enum typedef uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty, async active-low reset), reusable later for uart_rx_sb_ctrl.

Test Plan:
- Reset defaults, CLK_FREQ=10e6: read 0x08 -> 86. Read 0x04 -> 0. tx_o=1.
- Write DIVISOR=4, DATA=0xA5: tx_o sequence 0,1,0,1,0,0,1,0,1,1, each held exactly 4 cycles. STATUS busy=1 during the frame and 0 after the stop bit.
- PARITY_EN=1, STOPBIT=1, DIVISOR=4, DATA=0x07: the parity bit is 1, followed by 8 cycles high. Frame length 12 bits = 48 cycles.
- DIVISOR=4, write 6 bytes back-to-back (0x01..0x06):
  - STATUS = 0b111: overflow, full, busy.
  - Bytes 0x01..0x05 appear with no idle gap: 1 in shift register plus 4 in FIFO.
  - A second STATUS read -> overflow cleared.
- Write DIVISOR=8 while busy -> readback is unchanged. Write DIVISOR=0 when idle -> readback 2.
- Mid-frame write RESET=1: tx_o=1 next cycle, FIFO empty, divisor=86. Assert resetn_i mid-frame: tx_o=1 immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART system-bus peripherals: register offsets and
// the transmit state machine encoding.
package uart_pkg;

  localparam logic [31:0] REG_DATA      = 32'h00;
  localparam logic [31:0] REG_STATUS    = 32'h04;
  localparam logic [31:0] REG_DIVISOR   = 32'h08;
  localparam logic [31:0] REG_PARITY_EN = 32'h0C;
  localparam logic [31:0] REG_STOPBIT   = 32'h10;
  localparam logic [31:0] REG_RESET     = 32'h24;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers. A push into a full FIFO is dropped,
// even if a pop happens on the same cycle. clr_i empties it synchronously.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_tx_sb_ctrl.sv
// System-bus UART transmitter: register file, byte FIFO and a frame FSM that
// serialises 8N1/8E1/8N2/8E2 frames onto a registered tx line.
module uart_tx_sb_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 10_000_000,
  parameter int DEFAULT_BAUD = 115200,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        req_i,
  input  logic        write_enable_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        tx_o
);

  localparam logic [15:0] DIV_RESET = 16'(CLK_FREQ / DEFAULT_BAUD);

  uart_tx_state_t state_q;
  logic [15:0]    divisor_q;
  logic           parity_en_q;
  logic           stopbit_q;
  logic           overflow_q;
  logic [31:0]    read_data_q;
  logic           tx_q;
  logic [7:0]     shift_q;
  logic           par_q;
  logic [2:0]     bit_cnt_q;
  logic [16:0]    baud_cnt_q;

  logic       wr, rd, soft_rst, busy, bit_end;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;
  logic [16:0] bit_len, stop_len;
  logic       unused_wdata;

  assign wr        = req_i && write_enable_i;
  assign rd        = req_i && !write_enable_i;
  assign soft_rst  = wr && (addr_i == REG_RESET) && write_data_i[0];
  assign fifo_push = wr && (addr_i == REG_DATA);
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign bit_end   = (baud_cnt_q == '0);
  assign bit_len   = {1'b0, divisor_q} - 17'd1;
  assign stop_len  = stopbit_q ? ({divisor_q, 1'b0} - 17'd1) : bit_len;
  // A new frame is fetched from IDLE, or straight out of STOP for gapless streaming.
  assign fifo_pop  = !fifo_empty && ((state_q == IDLE) || (state_q == STOP && bit_end));
  assign unused_wdata = ^write_data_i[31:16];

  assign read_data_o = read_data_q;
  assign tx_o        = tx_q;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (resetn_i),
    .clr_i   (soft_rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (write_data_i[7:0]),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      divisor_q   <= DIV_RESET;
      parity_en_q <= 1'b0;
      stopbit_q   <= 1'b0;
      overflow_q  <= 1'b0;
      read_data_q <= '0;
    end else if (soft_rst) begin
      divisor_q   <= DIV_RESET;
      parity_en_q <= 1'b0;
      stopbit_q   <= 1'b0;
      overflow_q  <= 1'b0;
      read_data_q <= '0;
    end else begin
      if (fifo_push && fifo_full) overflow_q <= 1'b1;
      if (wr && !busy) begin
        case (addr_i)
          REG_DIVISOR:   divisor_q   <= (write_data_i[15:1] == '0) ? 16'd2 : write_data_i[15:0];
          REG_PARITY_EN: parity_en_q <= write_data_i[0];
          REG_STOPBIT:   stopbit_q   <= write_data_i[0];
          default: ;
        endcase
      end
      if (rd) begin
        case (addr_i)
          REG_STATUS: begin
            read_data_q <= {29'b0, overflow_q, fifo_full, busy};
            overflow_q  <= 1'b0;
          end
          REG_DIVISOR:   read_data_q <= {16'b0, divisor_q};
          REG_PARITY_EN: read_data_q <= {31'b0, parity_en_q};
          REG_STOPBIT:   read_data_q <= {31'b0, stopbit_q};
          default:       read_data_q <= '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
    end else if (soft_rst) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
    end else begin
      if (state_q != IDLE && !bit_end) baud_cnt_q <= baud_cnt_q - 17'd1;
      case (state_q)
        IDLE, STOP: begin
          if (fifo_pop) begin
            state_q    <= START;
            shift_q    <= fifo_rdata;
            par_q      <= ^fifo_rdata;
            tx_q       <= 1'b0;
            baud_cnt_q <= bit_len;
          end else if (state_q == STOP && bit_end) begin
            state_q <= IDLE;
          end
        end
        START: begin
          if (bit_end) begin
            state_q    <= DATA;
            tx_q       <= shift_q[0];
            bit_cnt_q  <= '0;
            baud_cnt_q <= bit_len;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt_q == 3'd7) begin
              if (parity_en_q) begin
                state_q    <= PARITY;
                tx_q       <= par_q;
                baud_cnt_q <= bit_len;
              end else begin
                state_q    <= STOP;
                tx_q       <= 1'b1;
                baud_cnt_q <= stop_len;
              end
            end else begin
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              shift_q    <= shift_q >> 1;
              tx_q       <= shift_q[1];
              baud_cnt_q <= bit_len;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q    <= STOP;
            tx_q       <= 1'b1;
            baud_cnt_q <= stop_len;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sb_ctrl.sv
// Bench for uart_tx_sb_ctrl: register-access vector table, hand-built frame
// sequences, randomized frames against a bit-level waveform model, and resets.
module tb_uart_tx_sb_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx;

  always #5 clk = ~clk;

  uart_tx_sb_ctrl #(.CLK_FREQ(10_000_000), .DEFAULT_BAUD(115200), .FIFO_DEPTH(4)) dut (
    .clk_i          (clk),
    .resetn_i       (resetn),
    .req_i          (req),
    .write_enable_i (we),
    .addr_i         (addr),
    .write_data_i   (wdata),
    .read_data_o    (rdata),
    .tx_o           (tx)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus tasks are entered at a negedge and return at the following negedge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    req = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    req = 1'b0;
    check(name, rdata, exp);
  endtask

  // Expected tx waveform, one entry per clock, starting at the first start bit.
  logic exp_q[$];
  logic mon_e;
  int   mon_state = 0;
  int   mon_wait = 0;

  task automatic model_bits(input logic b, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(b);
  endtask

  task automatic model_frame(input logic [7:0] b, input int div, input bit par, input bit stop2);
    model_bits(1'b0, div);
    for (int i = 0; i < 8; i++) model_bits(b[i], div);
    if (par) model_bits(^b, div);
    model_bits(1'b1, stop2 ? 2 * div : div);
  endtask

  task automatic arm_monitor();
    mon_wait = 0;
    mon_state = 1;
  endtask

  task automatic wait_monitor(input string name, input int limit);
    int n = 0;
    while (mon_state != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (mon_state != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: waveform incomplete after %0d cycles, %0d bits still expected", name, limit, exp_q.size());
      mon_state = 0;
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (mon_state == 1) begin
      if (tx === 1'b0) begin
        mon_state = 2;
      end else begin
        mon_wait++;
        if (mon_wait > 30) begin
          n_checks++;
          n_errors++;
          $display("FAIL frame_start: tx=%0b for 30 cycles, required start bit 0", tx);
          mon_state = 0;
          exp_q.delete();
        end
      end
    end
    if (mon_state == 2) begin
      mon_e = exp_q.pop_front();
      check("tx_bit", {31'b0, tx}, {31'b0, mon_e});
      if (exp_q.size() == 0) mon_state = 0;
    end
  end

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input bit w, input logic [31:0] a, input logic [31:0] d);
    vec_t v;
    v.wr = w; v.a = a; v.d = d;
    vecs.push_back(v);
  endtask

  initial begin
    #300_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a5_bits [10];
    logic [7:0] b;
    int div, nb, lows;
    bit par, st2;

    // Reset values
    #23;
    check("tx_in_reset", {31'b0, tx}, 32'd1);
    resetn = 1'b1;
    @(negedge clk);
    check("tx_after_reset", {31'b0, tx}, 32'd1);
    check("rdata_after_reset", rdata, 32'd0);

    // Register-access vectors: reads carry their expected value in d
    add_vec(0, 32'h08, 32'd86);
    add_vec(0, 32'h04, 32'd0);
    add_vec(0, 32'h0C, 32'd0);
    add_vec(0, 32'h10, 32'd0);
    add_vec(0, 32'h00, 32'd0);
    add_vec(0, 32'h24, 32'd0);
    add_vec(0, 32'h14, 32'd0);
    add_vec(1, 32'h08, 32'd0);
    add_vec(0, 32'h08, 32'd2);
    add_vec(1, 32'h08, 32'd1);
    add_vec(0, 32'h08, 32'd2);
    add_vec(1, 32'h08, 32'hABCD_1234);
    add_vec(0, 32'h08, 32'h1234);
    add_vec(1, 32'h0C, 32'hFFFF_FFFF);
    add_vec(0, 32'h0C, 32'd1);
    add_vec(1, 32'h10, 32'd3);
    add_vec(0, 32'h10, 32'd1);
    add_vec(1, 32'h04, 32'd7);
    add_vec(0, 32'h04, 32'd0);
    add_vec(1, 32'h20, 32'd5);
    add_vec(0, 32'h20, 32'd0);
    add_vec(1, 32'h0C, 32'd0);
    add_vec(1, 32'h10, 32'd0);
    add_vec(1, 32'h08, 32'd4);
    add_vec(1, 32'h24, 32'd2);
    add_vec(0, 32'h08, 32'd4);
    add_vec(0, 32'h0C, 32'd0);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) bus_write(vecs[i].a, vecs[i].d);
      else read_check($sformatf("vec%0d_rd_%0h", i, vecs[i].a), vecs[i].a, vecs[i].d);
    end

    // 0xA5, divisor 4, no parity, 1 stop: literal line levels
    a5_bits = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd1};
    exp_q.delete();
    for (int i = 0; i < 10; i++) model_bits(a5_bits[i][0], 4);
    model_bits(1'b1, 2);
    arm_monitor();
    bus_write(32'h00, 32'hA5);
    repeat (12) @(negedge clk);
    read_check("a5_status_busy", 32'h04, 32'd1);
    wait_monitor("a5_frame", 100);
    read_check("a5_status_idle", 32'h04, 32'd0);

    // Even parity + 2 stop bits
    bus_write(32'h0C, 32'd1);
    bus_write(32'h10, 32'd1);
    exp_q.delete();
    model_frame(8'h07, 4, 1'b1, 1'b1);
    model_bits(1'b1, 2);
    arm_monitor();
    bus_write(32'h00, 32'h07);
    wait_monitor("par_stop2_frame", 100);
    read_check("par_status_idle", 32'h04, 32'd0);

    // Overflow: six back-to-back bytes, five transmitted gaplessly
    bus_write(32'h0C, 32'd0);
    bus_write(32'h10, 32'd0);
    exp_q.delete();
    for (int i = 1; i <= 5; i++) model_frame(8'(i), 4, 1'b0, 1'b0);
    model_bits(1'b1, 2);
    arm_monitor();
    for (int i = 1; i <= 6; i++) bus_write(32'h00, 32'(i));
    read_check("ovf_status", 32'h04, 32'd7);
    req = 1'b1; we = 1'b0; addr = 32'h04;
    @(negedge clk);
    req = 1'b0;
    check("ovf_cleared", {31'b0, rdata[2]}, 32'd0);
    bus_write(32'h08, 32'd8);
    read_check("div_write_while_busy", 32'h08, 32'd4);
    wait_monitor("ovf_frames", 400);
    read_check("ovf_status_idle", 32'h04, 32'd0);
    bus_write(32'h08, 32'd0);
    read_check("div_zero_idle", 32'h08, 32'd2);

    // Randomized frame batches against the waveform model
    for (int it = 0; it < 10; it++) begin
      div = int'($urandom_range(2, 5));
      par = 1'($urandom_range(0, 1));
      st2 = 1'($urandom_range(0, 1));
      nb  = int'($urandom_range(1, 4));
      bus_write(32'h08, 32'(div));
      bus_write(32'h0C, {31'b0, par});
      bus_write(32'h10, {31'b0, st2});
      exp_q.delete();
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom);
        vecs[k].d = {24'b0, b};
        model_frame(b, div, par, st2);
      end
      model_bits(1'b1, 2);
      arm_monitor();
      for (int k = 0; k < nb; k++) bus_write(32'h00, vecs[k].d);
      wait_monitor($sformatf("rand%0d_frames", it), 2000);
      read_check($sformatf("rand%0d_status", it), 32'h04, 32'd0);
    end

    // Soft reset mid-frame with bytes still queued
    bus_write(32'h08, 32'd4);
    bus_write(32'h0C, 32'd0);
    bus_write(32'h10, 32'd0);
    bus_write(32'h00, 32'h00);
    bus_write(32'h00, 32'h11);
    repeat (10) @(negedge clk);
    check("soft_pre_tx_low", {31'b0, tx}, 32'd0);
    bus_write(32'h24, 32'd1);
    check("soft_tx_high", {31'b0, tx}, 32'd1);
    read_check("soft_status", 32'h04, 32'd0);
    read_check("soft_divisor", 32'h08, 32'd86);
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("soft_tx_stays_idle", 32'(lows), 32'd0);

    // Hardware reset mid-frame: asynchronous return to idle
    bus_write(32'h00, 32'h00);
    repeat (30) @(negedge clk);
    read_check("hw_pre_divisor", 32'h08, 32'd86);
    check("hw_pre_tx_low", {31'b0, tx}, 32'd0);
    #2 resetn = 1'b0;
    #1;
    check("hw_tx_async", {31'b0, tx}, 32'd1);
    check("hw_rdata_async", rdata, 32'd0);
    #3 resetn = 1'b1;
    @(negedge clk);
    read_check("hw_status", 32'h04, 32'd0);
    read_check("hw_divisor", 32'h08, 32'd86);
    repeat (5) @(negedge clk);
    check("hw_tx_idle", {31'b0, tx}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
